perf_counter_snapshot: RTL and testbench

- Parametrised Avalon-MM performance counter for Nios II systems; next generation of the fixed 8-section, 64-bit section counter.
- Each section has a time counter (clock cycles while running) and an event counter.
- New versus the previous generation:
  - atomic 64-bit time reads through a high-word snapshot
  - per-section clear
  - sticky overflow flags and a status register
  - optional counting of external event pulses

---
 rtl/perf_counter_snapshot.sv | 210 +++++++++++++++++++++
 tb/tb_perf_counter_snapshot.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_snapshot.sv
// ---------------------------------------------------------------------------
// perf_counter_snapshot
//
// Avalon-MM performance counter with NUM_SECTIONS independent sections. Each
// section owns a TIME_W-bit cycle counter and an EVENT_W-bit event counter.
// Reading a section's low time word also captures the upper time bits into
// a snapshot register, so software gets a coherent 64-bit value from two reads.
//
// Register map, section s (word addresses):
//   4s+0  write: stop s (bit0=1 on section 0 = global reset)   read: time[31:0]
//   4s+1  write: go s                                          read: snapshot hi
//   4s+2  write: clear s                                       read: event count
//   4s+3  write: ack overflow (bit0 tovf, bit1 eovf)           read: status
//   status = {29'b0, eovf, tovf, run}
//
// Ports:
//   clk           single clock
//   reset_n       asynchronous active-low reset
//   address       word address (5 bits)
//   begintransfer first cycle of an Avalon transfer
//   read, write   transfer requests (qualified by begintransfer)
//   writedata     write data
//   event_in      per-section event pulses (used when EVENT_MODE = 1)
//   readdata      registered read data, latency 1
// ---------------------------------------------------------------------------
module perf_counter_snapshot #(
    parameter int NUM_SECTIONS = 8,
    parameter int TIME_W       = 64,
    parameter int EVENT_W      = 32,
    parameter int EVENT_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4:0]              address,
    input  logic                    begintransfer,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [NUM_SECTIONS-1:0] event_in,
    output logic [31:0]             readdata
);

    // Bus strobes: only the first cycle of a transfer acts.
    logic       w_wr;
    logic       w_rd;
    logic [2:0] w_sec;
    logic [1:0] w_off;

    assign w_wr  = write & begintransfer;
    assign w_rd  = read & begintransfer;
    assign w_sec = address[4:2];
    assign w_off = address[1:0];

    // Section 0 doubles as the global control section.
    logic                    w_stop0;
    logic                    w_go0;
    logic                    w_global_reset;
    logic                    w_global_enable;
    logic [NUM_SECTIONS-1:0] w_run_vec;

    assign w_stop0         = w_wr & (address == 5'd0);
    assign w_go0           = w_wr & (address == 5'd1);
    assign w_global_reset  = w_stop0 & writedata[0];
    assign w_global_enable = w_run_vec[0] | w_go0;

    // Upper writedata bits carry no meaning in any register.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, writedata[31:2]};

    // Per-section read words, selected into readdata below.
    logic [31:0] w_word [NUM_SECTIONS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
            logic               r_run;
            logic [TIME_W-1:0]  r_time;
            logic [EVENT_W-1:0] r_event;
            logic               r_tovf;
            logic               r_eovf;
            logic [31:0]        r_snap_hi;

            logic w_sel;
            logic w_stop;
            logic w_go;
            logic w_clr;
            logic w_ack;
            logic w_snap;
            logic w_clear;
            logic w_time_inc;
            logic w_time_wrap;
            logic w_evt_src;
            logic w_evt_inc;
            logic w_evt_wrap;
            logic [31:0] w_word_sel;

            // Addresses beyond the last section never match any w_sec,
            // so those writes are dropped and reads fall to zero.
            assign w_sel  = (w_sec == 3'(gi));
            assign w_stop = w_wr & w_sel & (w_off == 2'd0);
            assign w_go   = w_wr & w_sel & (w_off == 2'd1);
            assign w_clr  = w_wr & w_sel & (w_off == 2'd2);
            assign w_ack  = w_wr & w_sel & (w_off == 2'd3);
            assign w_snap = w_rd & w_sel & (w_off == 2'd0);

            assign w_clear     = w_global_reset | w_clr;
            assign w_time_inc  = r_run & w_global_enable;
            assign w_time_wrap = w_time_inc & (&r_time);

            // Legacy mode counts go writes; mode 1 counts external pulses
            // that arrive while the section is running.
            assign w_evt_src  = (EVENT_MODE == 1) ? (event_in[gi] & r_run) : w_go;
            assign w_evt_inc  = w_evt_src & w_global_enable;
            assign w_evt_wrap = w_evt_inc & (&r_event);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_run     <= 1'b0;
                    r_time    <= '0;
                    r_event   <= '0;
                    r_tovf    <= 1'b0;
                    r_eovf    <= 1'b0;
                    r_snap_hi <= '0;
                end else begin
                    // Run flag: global reset beats go.
                    if (w_global_reset || w_stop) begin
                        r_run <= 1'b0;
                    end else if (w_go) begin
                        r_run <= 1'b1;
                    end

                    if (w_clear) begin
                        r_time <= '0;
                    end else if (w_time_inc) begin
                        r_time <= r_time + 1'b1;
                    end

                    if (w_clear) begin
                        r_event <= '0;
                    end else if (w_evt_inc) begin
                        r_event <= r_event + 1'b1;
                    end

                    // A wrap in the ack cycle keeps the flag set, so an
                    // overflow is never lost to a racing acknowledge.
                    if (w_clear) begin
                        r_tovf <= 1'b0;
                    end else if (w_time_wrap) begin
                        r_tovf <= 1'b1;
                    end else if (w_ack && writedata[0]) begin
                        r_tovf <= 1'b0;
                    end

                    if (w_clear) begin
                        r_eovf <= 1'b0;
                    end else if (w_evt_wrap) begin
                        r_eovf <= 1'b1;
                    end else if (w_ack && writedata[1]) begin
                        r_eovf <= 1'b0;
                    end

                    // Capture the high bits of the same counter value whose
                    // low word is being returned in this cycle.
                    if (w_clear) begin
                        r_snap_hi <= '0;
                    end else if (w_snap) begin
                        r_snap_hi <= 32'(r_time[TIME_W-1:32]);
                    end
                end
            end

            always_comb begin
                w_word_sel = '0;
                case (w_off)
                    2'd0:    w_word_sel = r_time[31:0];
                    2'd1:    w_word_sel = r_snap_hi;
                    2'd2:    w_word_sel = 32'(r_event);
                    default: w_word_sel = {29'b0, r_eovf, r_tovf, r_run};
                endcase
            end

            assign w_word[gi]    = w_word_sel;
            assign w_run_vec[gi] = r_run;
        end
    endgenerate

    // Read mux: out-of-range addresses select nothing and return zero.
    logic [31:0] w_readdata_next;
    logic [31:0] r_readdata;

    always_comb begin
        w_readdata_next = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (w_sec == 3'(s)) begin
                w_readdata_next = w_word[s];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_readdata_next;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_perf_counter_snapshot.sv
// ---------------------------------------------------------------------------
// tb_perf_counter_snapshot
//
// Three instances share one Avalon bus:
//   dut 0 (a): defaults, 8 sections, 64-bit time, 32-bit events, go counting
//   dut 1 (b): 4 sections, 33-bit time, 4-bit events, go counting
//   dut 2 (c): 4 sections, 40-bit time, 8-bit events, event_in counting
// Reads push their expected word into a queue; a monitor pops and compares
// one cycle after each read strobe.
// ---------------------------------------------------------------------------
module tb_perf_counter_snapshot;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  address;
    logic        begintransfer;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  ev;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [31:0] rd_c;

    always #5 clk = ~clk;

    perf_counter_snapshot dut_a (
        .clk(clk), .reset_n(reset_n), .address(address),
        .begintransfer(begintransfer), .read(read), .write(write),
        .writedata(writedata), .event_in(ev), .readdata(rd_a)
    );

    perf_counter_snapshot #(
        .NUM_SECTIONS(4), .TIME_W(33), .EVENT_W(4), .EVENT_MODE(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address),
        .begintransfer(begintransfer), .read(read), .write(write),
        .writedata(writedata), .event_in(ev[3:0]), .readdata(rd_b)
    );

    perf_counter_snapshot #(
        .NUM_SECTIONS(4), .TIME_W(40), .EVENT_W(8), .EVENT_MODE(1)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address),
        .begintransfer(begintransfer), .read(read), .write(write),
        .writedata(writedata), .event_in(ev[3:0]), .readdata(rd_c)
    );

    typedef struct {
        int          dut;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic rd_seen = 1'b0;

    function automatic logic [31:0] pick(int d);
        case (d)
            0:       return rd_a;
            1:       return rd_b;
            default: return rd_c;
        endcase
    endfunction

    function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
        end
    endfunction

    // Monitor: readdata is valid one cycle after the read strobe.
    always @(posedge clk) rd_seen <= read & begintransfer;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", rd_a);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("RD  dut=%0d %-22s data=0x%08h exp=0x%08h",
                         e.dut, e.name, pick(e.dut), e.exp);
                check(e.name, pick(e.dut), e.exp);
            end
        end
    end

    // All tasks start and end on a falling edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        address       = a;
        writedata     = d;
        write         = 1'b1;
        begintransfer = 1'b1;
        @(negedge clk);
        write         = 1'b0;
        begintransfer = 1'b0;
        $display("WR  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input int d, input logic [4:0] a, input logic [31:0] e,
                      input string n);
        address       = a;
        read          = 1'b1;
        begintransfer = 1'b1;
        q.push_back('{dut: d, exp: e, name: n});
        @(negedge clk);
        read          = 1'b0;
        begintransfer = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse3();
        ev[3] = 1'b1;
        @(negedge clk);
        ev[3] = 1'b0;
        $display("EV  event_in[3] pulse");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        address       = '0;
        begintransfer = 1'b0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        ev            = '0;
        repeat (2) @(negedge clk);
        check("reset_readdata_a", rd_a, 32'h0);
        check("reset_readdata_b", rd_b, 32'h0);
        check("reset_readdata_c", rd_c, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: run section 0 for 100 cycles between go and stop.
        wr(5'd0, 32'h1);
        wr(5'd1, 32'h0);
        idle(99);
        wr(5'd0, 32'h0);
        rd(0, 5'd0, 32'd100, "t1_time0");
        rd(0, 5'd1, 32'd0,   "t1_snaphi0");
        rd(0, 5'd2, 32'd1,   "t1_event0");
        rd(0, 5'd3, 32'd0,   "t1_status0");

        // 2: 33-bit time crossing 2^32, snapshot coherence and hold.
        wr(5'd0, 32'h1);
        wr(5'd1, 32'h0);
        wr(5'd5, 32'h0);
        force dut_b.g_sec[1].r_time = 33'h0_FFFF_FFFD;
        #1;
        release dut_b.g_sec[1].r_time;
        @(negedge clk);
        idle(4);
        rd(1, 5'd4, 32'd2, "t2_time1_lo");
        rd(1, 5'd5, 32'd1, "t2_time1_hi");
        idle(3);
        rd(1, 5'd5, 32'd1, "t2_snap_hold");
        rd(1, 5'd6, 32'd1, "t2_event1");
        rd(1, 5'd7, 32'd1, "t2_status1");
        // wrap in the same cycle as an ack: flag must stay set
        force dut_b.g_sec[1].r_time = 33'h1_FFFF_FFFF;
        #1;
        release dut_b.g_sec[1].r_time;
        wr(5'd7, 32'h1);
        rd(1, 5'd7, 32'd3, "t2_wrap_beats_ack");
        wr(5'd7, 32'h1);
        rd(1, 5'd7, 32'd1, "t2_ack_tovf");
        // per-section clear
        rd(1, 5'd5, 32'd1, "t2_snap_before_clr");
        wr(5'd6, 32'h0);
        rd(1, 5'd5, 32'd0, "t2_clr_snap");
        rd(1, 5'd6, 32'd0, "t2_clr_event");
        rd(1, 5'd7, 32'd1, "t2_clr_keeps_run");
        rd(1, 5'd3, 32'd1, "t2_clr_other_sec");

        // 3: 4-bit event counter wraps after 16 go writes.
        wr(5'd0, 32'h1);
        wr(5'd1, 32'h0);
        for (int i = 0; i < 17; i++) wr(5'd9, 32'h0);
        rd(1, 5'd10, 32'd1, "t3_event_wrap");
        rd(1, 5'd11, 32'd5, "t3_status_eovf");
        wr(5'd11, 32'h2);
        rd(1, 5'd11, 32'd1, "t3_ack_eovf");

        // 4: event_in counting, pulses while stopped are ignored.
        wr(5'd0, 32'h1);
        wr(5'd1, 32'h0);
        wr(5'd13, 32'h0);
        repeat (5) pulse3();
        wr(5'd12, 32'h0);
        repeat (2) pulse3();
        rd(2, 5'd14, 32'd5, "t4_events");
        rd(2, 5'd15, 32'd0, "t4_status");

        // 5: global reset while running, then a plain stop of section 0.
        wr(5'd0, 32'h1);
        wr(5'd1, 32'h0);
        wr(5'd5, 32'h0);
        idle(10);
        wr(5'd0, 32'h1);
        rd(0, 5'd0, 32'd0, "t5_gr_time0");
        rd(0, 5'd2, 32'd0, "t5_gr_event0");
        rd(0, 5'd3, 32'd0, "t5_gr_status0");
        rd(0, 5'd4, 32'd0, "t5_gr_time1");
        rd(0, 5'd7, 32'd0, "t5_gr_status1");
        wr(5'd1, 32'h0);
        wr(5'd5, 32'h0);
        idle(8);
        wr(5'd0, 32'h0);
        rd(0, 5'd0, 32'd10, "t5_stop_time0");
        rd(0, 5'd2, 32'd1,  "t5_stop_event0");
        rd(0, 5'd3, 32'd0,  "t5_stop_status0");
        rd(0, 5'd4, 32'd9,  "t5_stop_time1");
        rd(0, 5'd6, 32'd1,  "t5_stop_event1");
        rd(0, 5'd7, 32'd1,  "t5_stop_status1");

        // 6: asynchronous reset mid-count, then out-of-range reads.
        wr(5'd1, 32'h0);
        address = 5'd0;
        idle(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_readdata_a", rd_a, 32'h0);
        check("t6_async_readdata_b", rd_b, 32'h0);
        check("t6_async_time0", dut_a.g_sec[0].r_time[31:0], 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 5'd0, 32'd0, "t6_time0");
        rd(0, 5'd3, 32'd0, "t6_status0");
        rd(0, 5'd4, 32'd0, "t6_time1");
        rd(0, 5'd7, 32'd0, "t6_status1");
        wr(5'd1, 32'h0);
        idle(3);
        rd(2, 5'd16, 32'd0, "t6_oor16");
        rd(2, 5'd31, 32'd0, "t6_oor31");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending reads, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
